// File: rtl/sensor_packet_streamer_if.sv
// Sample-in / framed-word-out bundle for sensor_packet_streamer.
// The master side is the streamer; the slave side is the sensor/UART environment.
interface sensor_packet_streamer_if #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 24
);
  logic [N_CH*SAMPLE_W-1:0] i_sample;
  logic [N_CH-1:0]          i_sample_valid;
  logic [SAMPLE_W+15:0]     o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_ready;

  modport master (
    input  i_sample, i_sample_valid, i_tx_ready,
    output o_tx_data, o_tx_valid
  );

  modport slave (
    output i_sample, i_sample_valid, i_tx_ready,
    input  o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/sensor_packet_streamer.sv
// Multi-channel sample streamer: per-channel holding registers, round-robin arbiter,
// FIFO and an output register emitting {SYNC, ch_id, seq, sample} words.
module sensor_packet_streamer #(
  parameter int          N_CH       = 4,
  parameter int          SAMPLE_W   = 24,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_enable,
  input  logic                          i_clear_stats,
  output logic [15:0]                   o_overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_busy,
  sensor_packet_streamer_if.master      bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]          ch;
    logic [3:0]          seq;
    logic [SAMPLE_W-1:0] sample;
  } entry_t;

  logic [SAMPLE_W-1:0] hold_q [N_CH];
  logic [SAMPLE_W-1:0] hold_d [N_CH];
  logic [3:0]          seq_q  [N_CH];
  logic [3:0]          seq_d  [N_CH];
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;

  entry_t              mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic [15:0]         ovf_q, ovf_d;
  logic                tx_valid_q, tx_valid_d;
  entry_t              tx_q, tx_d;

  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W-1:0]     cand;
  logic [N_CH-1:0]     grant_oh;
  logic                fifo_full, do_write, do_read;
  logic [4:0]          drop_cnt;
  logic [16:0]         ovf_sum;
  entry_t              wr_entry;

  // Round-robin: first pending channel strictly after the last one granted.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(last_grant_q) + i) % N_CH);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_write  = grant_found && !fifo_full;
  assign do_read   = (count_q != '0) && (!tx_valid_q || bus.i_tx_ready);

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < N_CH; k++) begin
      grant_oh[k] = do_write && (grant_idx == CH_W'(k));
    end
  end

  // A capture onto a still-pending, ungranted channel overwrites it and counts one drop.
  always_comb begin
    drop_cnt = '0;
    for (int k = 0; k < N_CH; k++) begin
      hold_d[k]    = hold_q[k];
      pending_d[k] = pending_q[k] & ~grant_oh[k];
      if (i_enable && bus.i_sample_valid[k]) begin
        hold_d[k]    = bus.i_sample[k*SAMPLE_W +: SAMPLE_W];
        pending_d[k] = 1'b1;
        if (pending_q[k] && !grant_oh[k]) drop_cnt = drop_cnt + 5'd1;
      end
      if (i_clear_stats)    seq_d[k] = 4'd0;
      else if (grant_oh[k]) seq_d[k] = seq_q[k] + 4'd1;
      else                  seq_d[k] = seq_q[k];
    end
  end

  always_comb begin
    ovf_sum = {1'b0, ovf_q} + 17'(drop_cnt);
    if (i_clear_stats)   ovf_d = '0;
    else if (ovf_sum[16]) ovf_d = 16'hFFFF;
    else                 ovf_d = ovf_sum[15:0];
  end

  always_comb begin
    wr_entry.ch     = 4'(grant_idx);
    wr_entry.seq    = seq_q[grant_idx];
    wr_entry.sample = hold_q[grant_idx];
    last_grant_d    = do_write ? grant_idx : last_grant_q;
    wr_ptr_d        = wr_ptr_q + AW'(do_write);
    rd_ptr_d        = rd_ptr_q + AW'(do_read);
    count_d         = count_q + (AW+1)'(do_write) - (AW+1)'(do_read);
  end

  // Output register: refills whenever empty or its word is taken; holds while stalled.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_d       = tx_q;
    if (do_read) begin
      tx_valid_d = 1'b1;
      tx_d       = mem[rd_ptr_q];
    end else if (bus.i_tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // NOTE: FIFO storage is not reset; the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (rstn && do_write) mem[wr_ptr_q] <= wr_entry;
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q    <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_q         <= '0;
      for (int k = 0; k < N_CH; k++) begin
        hold_q[k] <= '0;
        seq_q[k]  <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      tx_valid_q   <= tx_valid_d;
      tx_q         <= tx_d;
      hold_q       <= hold_d;
      seq_q        <= seq_d;
    end
  end

  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_data  = tx_valid_q ? {SYNC_BYTE, tx_q} : '0;
  assign o_overflow_cnt = ovf_q;
  assign o_fifo_level   = count_q;
  assign o_busy         = (|pending_q) || (count_q != '0) || tx_valid_q;

endmodule

// File: tb/tb_sensor_packet_streamer.sv
// Directed bench for sensor_packet_streamer: latency, arbitration order, overflow,
// stall stability, reset mid-traffic, enable gating and statistics clear.
module tb_sensor_packet_streamer;

  localparam int N_CH = 4;
  localparam int SW   = 24;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_enable;
  logic        i_clear_stats;
  logic [15:0] o_overflow_cnt;
  logic [4:0]  o_fifo_level;
  logic        o_busy;

  sensor_packet_streamer_if #(.N_CH(N_CH), .SAMPLE_W(SW)) bus ();

  sensor_packet_streamer #(.N_CH(N_CH), .SAMPLE_W(SW), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_enable       (i_enable),
    .i_clear_stats  (i_clear_stats),
    .o_overflow_cnt (o_overflow_cnt),
    .o_fifo_level   (o_fifo_level),
    .o_busy         (o_busy),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: records accepted words and watches stall stability.
  logic [39:0] got_q [$];
  logic        prev_stall = 1'b0;
  logic [39:0] prev_data  = '0;
  int          stall_viol = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.o_tx_valid || bus.o_tx_data !== prev_data)) stall_viol++;
      if (bus.o_tx_valid && bus.i_tx_ready) got_q.push_back(bus.o_tx_data);
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int k, input logic [SW-1:0] v);
    bus.i_sample[k*SW +: SW] = v;
  endtask

  task automatic do_reset();
    rstn               = 1'b0;
    i_enable           = 1'b1;
    i_clear_stats      = 1'b0;
    bus.i_sample       = '0;
    bus.i_sample_valid = '0;
    bus.i_tx_ready     = 1'b1;
    tick();
    rstn = 1'b1;
    got_q.delete();
  endtask

  function automatic logic [39:0] word(input logic [3:0] ch, input logic [3:0] seq, input logic [23:0] s);
    return {8'hA5, ch, seq, s};
  endfunction

  int          captures;
  int          bad;
  int          qsize;
  logic [3:0]  last_seq [N_CH];
  logic [23:0] last_smp [N_CH];
  logic        seen     [N_CH];
  logic [39:0] w;

  initial begin
    do_reset();
    check("rst_valid", bus.o_tx_valid, 0);
    check("rst_data",  bus.o_tx_data,  0);
    check("rst_ovf",   o_overflow_cnt, 0);
    check("rst_level", o_fifo_level,   0);
    check("rst_busy",  o_busy,         0);

    // Single sample, three-cycle latency, one-cycle word
    set_sample(2, 24'h123456);
    bus.i_sample_valid = 4'b0100;
    tick();
    bus.i_sample_valid = '0;
    check("t1_busy_hold", o_busy, 1);
    tick();
    check("t1_early_valid", bus.o_tx_valid, 0);
    tick();
    check("t1_valid", bus.o_tx_valid, 1);
    check("t1_data",  bus.o_tx_data,  40'hA5_2_0_123456);
    tick();
    check("t1_one_cycle", bus.o_tx_valid, 0);
    check("t1_ovf", o_overflow_cnt, 0);

    // All channels in one cycle: ch0..ch3 back to back
    do_reset();
    for (int k = 0; k < N_CH; k++) set_sample(k, 24'(k + 1));
    bus.i_sample_valid = 4'b1111;
    tick();
    bus.i_sample_valid = '0;
    tick();
    tick();
    for (int k = 0; k < N_CH; k++) begin
      check($sformatf("t2_valid%0d", k), bus.o_tx_valid, 1);
      check($sformatf("t2_word%0d", k), bus.o_tx_data, word(4'(k), 4'd0, 24'(k + 1)));
      tick();
    end
    check("t2_end_valid", bus.o_tx_valid, 0);
    check("t2_ovf", o_overflow_cnt, 0);

    // Sustained ch0 traffic into a stalled consumer
    do_reset();
    bus.i_tx_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      set_sample(0, 24'(n));
      bus.i_sample_valid = 4'b0001;
      tick();
    end
    bus.i_sample_valid = '0;
    check("t3_ovf",   o_overflow_cnt, 22);
    check("t3_level", o_fifo_level,   16);
    tick();
    tick();
    check("t3_ovf_stable", o_overflow_cnt, 22);
    bus.i_tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("t3_count", got_q.size(), 18);
    if (got_q.size() == 18) begin
      for (int i = 0; i <= 16; i++)
        check($sformatf("t3_word%0d", i), got_q[i], word(4'd0, 4'(i % 16), 24'(i)));
      check("t3_word17", got_q[17], word(4'd0, 4'd1, 24'd39));
    end

    // Random ready under multi-channel traffic: order, seq continuity, conservation
    do_reset();
    captures = 0;
    for (int c = 0; c < 300; c++) begin
      bus.i_tx_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < N_CH; k++) begin
        set_sample(k, {4'(k), 20'(c)});
        bus.i_sample_valid[k] = ($urandom_range(0, 2) == 0);
        if (bus.i_sample_valid[k]) captures++;
      end
      tick();
    end
    bus.i_sample_valid = '0;
    bus.i_tx_ready     = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    check("t4_conserve", got_q.size() + int'(o_overflow_cnt), captures);
    check("t4_drained", o_busy, 0);
    bad = 0;
    for (int k = 0; k < N_CH; k++) seen[k] = 1'b0;
    foreach (got_q[i]) begin
      w = got_q[i];
      if (w[39:32] != 8'hA5 || w[23:20] != w[31:28]) bad++;
      else begin
        if (seen[w[29:28]] && (w[27:24] != last_seq[w[29:28]] + 4'd1 ||
                               w[23:0] <= last_smp[w[29:28]])) bad++;
        seen[w[29:28]]     = 1'b1;
        last_seq[w[29:28]] = w[27:24];
        last_smp[w[29:28]] = w[23:0];
      end
    end
    check("t4_order_seq", bad, 0);
    check("t4_first_seq0", got_q.size() > 0 ? got_q[0][27:24] : 4'hF, 0);

    // Reset with a partly filled FIFO
    do_reset();
    bus.i_tx_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      set_sample(0, 24'(n + 100));
      bus.i_sample_valid = 4'b0001;
      tick();
    end
    bus.i_sample_valid = '0;
    tick();
    tick();
    tick();
    check("t5_level8", o_fifo_level, 8);
    check("t5_valid_pre", bus.o_tx_valid, 1);
    rstn = 1'b0;
    tick();
    check("t5_valid", bus.o_tx_valid, 0);
    check("t5_level", o_fifo_level,   0);
    check("t5_ovf",   o_overflow_cnt, 0);
    check("t5_busy",  o_busy,         0);
    rstn = 1'b1;
    bus.i_tx_ready = 1'b1;
    set_sample(1, 24'hABCDEF);
    bus.i_sample_valid = 4'b0010;
    tick();
    bus.i_sample_valid = '0;
    tick();
    tick();
    check("t5_post_valid", bus.o_tx_valid, 1);
    check("t5_post_word",  bus.o_tx_data,  40'hA5_1_0_ABCDEF);

    // Drops on several channels in one cycle, enable gating, stats clear
    do_reset();
    bus.i_tx_ready = 1'b0;
    for (int k = 0; k < N_CH; k++) set_sample(k, 24'(k + 16));
    bus.i_sample_valid = 4'b1111;
    tick();
    tick();
    bus.i_sample_valid = '0;
    check("t6_multi_drop", o_overflow_cnt, 3);
    bus.i_tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    qsize = got_q.size();
    i_enable = 1'b0;
    bus.i_sample_valid = 4'b1111;
    tick();
    bus.i_sample_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    check("t6_dis_words", got_q.size(), qsize);
    check("t6_dis_ovf",   o_overflow_cnt, 3);
    check("t6_dis_busy",  o_busy, 0);
    check("t6_dis_level", o_fifo_level, 0);
    i_enable      = 1'b1;
    i_clear_stats = 1'b1;
    tick();
    i_clear_stats = 1'b0;
    check("t6_clear_ovf", o_overflow_cnt, 0);
    set_sample(0, 24'h000777);
    bus.i_sample_valid = 4'b0001;
    tick();
    bus.i_sample_valid = '0;
    tick();
    tick();
    check("t6_clear_seq", bus.o_tx_data, 40'hA5_0_0_000777);

    check("stall_hold_stable", stall_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
